// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to a keyboard over the shared open-drain
// ps2_clk / ps2_data pins: inhibit, start bit, 8 data bits LSB first,
// odd parity, stop bit, then samples the device ACK.
`timescale 1ns/1ps
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       sys_rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int             CW           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  TIMER_MAX    = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0]  INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RELEASE,
      SHIFT,
      WAIT_IDLE
   } state_t;

   state_t        state;
   logic [CW-1:0] timer;
   logic [3:0]    bit_cnt;
   logic [7:0]    byte_q;
   logic          parity_q;
   logic          ack_ok;

   logic          clk_meta, clk_sync, clk_prev;
   logic          data_meta, data_sync;
   logic          fall;

   // Two-flop synchronisers for the asynchronous pins, plus one delayed copy of clk for edge detection.
   // Reset to the idle (high) level so leaving reset never looks like a falling edge.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         clk_meta  <= ps2_clk_in;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= ps2_data_in;
         data_sync <= data_meta;
      end
   end

   assign fall = clk_prev & ~clk_sync;

   // Transmit FSM: all handshake and pin-enable outputs are registered here.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= IDLE;
         timer       <= '0;
         bit_cnt     <= '0;
         byte_q      <= '0;
         parity_q    <= 1'b0;
         ack_ok      <= 1'b0;
         tx_ready    <= 1'b1;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         case (state)
            IDLE: begin
               tx_ready    <= 1'b1;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               if (tx_valid && tx_ready) begin
                  byte_q     <= tx_data;
                  parity_q   <= ~^tx_data;
                  tx_ready   <= 1'b0;
                  ps2_clk_oe <= 1'b1;
                  // The accept edge already starts the first inhibit cycle, the
                  // RELEASE cycle ends it, so the count begins at 1.
                  timer      <= {{(CW-1){1'b0}}, 1'b1};
                  state      <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (timer >= INHIBIT_LAST) begin
                  ps2_data_oe <= 1'b1;  // start bit, set while clk is still held low
                  state       <= RELEASE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            RELEASE: begin
               ps2_clk_oe <= 1'b0;
               bit_cnt    <= '0;
               timer      <= '0;
               state      <= SHIFT;
            end

            SHIFT: begin
               if (fall) begin
                  timer   <= '0;
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt < 4'd8) begin
                     ps2_data_oe <= ~byte_q[bit_cnt[2:0]];
                  end else if (bit_cnt == 4'd8) begin
                     ps2_data_oe <= ~parity_q;
                  end else if (bit_cnt == 4'd9) begin
                     ps2_data_oe <= 1'b0;  // stop bit: line released high
                  end else begin
                     ack_ok <= ~data_sync;  // fall 11: device pulls data low to ACK
                     state  <= WAIT_IDLE;
                  end
               end else if (timer == TIMEOUT_LAST) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_err      <= 1'b1;
                  tx_ready    <= 1'b1;
                  state       <= IDLE;
               end else if (timer != TIMER_MAX) begin
                  timer <= timer + 1'b1;
               end
            end

            WAIT_IDLE: begin
               if (clk_sync && data_sync) begin
                  tx_done  <= ack_ok;
                  tx_err   <= ~ack_ok;
                  tx_ready <= 1'b1;
                  state    <= IDLE;
               end else if (fall) begin
                  timer <= '0;
               end else if (timer == TIMEOUT_LAST) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  tx_err      <= 1'b1;
                  tx_ready    <= 1'b1;
                  state       <= IDLE;
               end else if (timer != TIMER_MAX) begin
                  timer <= timer + 1'b1;
               end
            end

            default: begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               tx_ready    <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed + randomized bench with an open-drain PS/2 device model.
// The device clocks at a 40-cycle period, samples data while ps2_clk is high
// and optionally ACKs; expected frames are built from the byte with $countones.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int TMO  = 500;
   localparam int HALF = 20;

   logic       clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_done, tx_err;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       ps2_clk_in, ps2_data_in;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int n_done  = 0;
   int n_err   = 0;
   int n_both  = 0;
   bit scramble = 1'b0;

   // Open-drain wired-AND of host and device on both lines.
   assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   // Pulse monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (tx_done) n_done <= n_done + 1;
      if (tx_err) n_err <= n_err + 1;
      if (tx_done && tx_err) n_both <= n_both + 1;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: observed time limit expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] exp_frame(input logic [7:0] b);
      logic p;
      p = (($countones(b) % 2) == 0);  // odd parity over data + parity bit
      return {1'b1, p, b, 1'b0};
   endfunction

   task automatic tick();
      @(negedge clk);
      if (scramble) tx_data = 8'($urandom);
   endtask

   task automatic start_tx(input logic [7:0] b, input bit hold, input string tag);
      check({tag, "_ready_before"}, tx_ready, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      tick();
      check({tag, "_ready_dropped"}, tx_ready, 0);
      if (!hold) tx_valid = 1'b0;
   endtask

   // Counts negedge samples with clk_oe high, starting at the current sample.
   task automatic measure_inhibit(input string tag);
      int n;
      n = 0;
      while (ps2_clk_oe && n < 200) begin
         n++;
         tick();
      end
      check({tag, "_inhibit_len"}, n, INH);
      check({tag, "_start_oe"}, ps2_data_oe, 1);
      check({tag, "_start_line"}, ps2_data_in, 0);
   endtask

   task automatic clock_pulse();
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      dev_clk_low = 1'b0;
      tick();
   endtask

   task automatic run_device(input bit give_ack, output logic [10:0] frame);
      frame = '0;
      repeat (5) tick();
      frame[0] = ps2_data_in;
      for (int k = 1; k <= 11; k++) begin
         if (k == 11 && give_ack) begin
            dev_data_low = 1'b1;
            repeat (5) tick();
         end
         clock_pulse();
         if (k <= 10) frame[k] = ps2_data_in;
         repeat (HALF - 1) tick();
      end
      dev_data_low = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!tx_ready && n < 300) begin
         tick();
         n++;
      end
      check({tag, "_ready_back"}, tx_ready, 1);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit ack, input string tag);
      int d0, e0;
      logic [10:0] fr;
      d0 = n_done;
      e0 = n_err;
      start_tx(b, 1'b0, tag);
      measure_inhibit(tag);
      run_device(ack, fr);
      check({tag, "_frame"}, fr, exp_frame(b));
      wait_ready(tag);
      tick();
      check({tag, "_done_cnt"}, n_done - d0, ack ? 1 : 0);
      check({tag, "_err_cnt"}, n_err - e0, ack ? 0 : 1);
      check({tag, "_oe_released"}, {ps2_clk_oe, ps2_data_oe}, 0);
   endtask

   initial begin
      int d0, e0, n;
      logic [10:0] fr;
      logic [7:0] captured;

      // Reset state
      repeat (3) tick();
      check("rst_ready", tx_ready, 1);
      check("rst_pulses", {tx_done, tx_err}, 0);
      check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      sys_rst = 1'b0;
      repeat (3) tick();
      check("idle_ready", tx_ready, 1);

      // 1/2: directed bytes and parity corners
      send_frame(8'hED, 1'b1, "ed");
      send_frame(8'h01, 1'b1, "b01");
      send_frame(8'hFF, 1'b1, "bff");
      send_frame(8'h00, 1'b1, "b00");
      for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, "rand");

      // 3: no ACK
      send_frame(8'h55, 1'b0, "noack");

      // 4: device never clocks after release
      d0 = n_done;
      e0 = n_err;
      start_tx(8'h3C, 1'b0, "tmo");
      measure_inhibit("tmo");
      n = 0;
      while (!tx_err && n < 1000) begin
         tick();
         n++;
      end
      check("tmo_latency", n, TMO);
      tick();
      check("tmo_ready_next", tx_ready, 1);
      check("tmo_oe_next", {ps2_clk_oe, ps2_data_oe}, 0);
      check("tmo_err_once", n_err - e0, 1);
      check("tmo_no_done", n_done - d0, 0);

      // 5: reset after fall 4
      start_tx(8'hA5, 1'b0, "rst");
      measure_inhibit("rst");
      repeat (5) tick();
      for (int k = 0; k < 3; k++) begin
         clock_pulse();
         repeat (HALF - 1) tick();
      end
      dev_clk_low = 1'b1;
      repeat (10) tick();
      check("rst_bit3_driven", ps2_data_oe, 1);  // 0xA5 bit3 = 0
      d0 = n_done;
      e0 = n_err;
      #2 sys_rst = 1'b1;
      #1 check("rst_async_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      dev_clk_low = 1'b0;
      repeat (3) tick();
      sys_rst = 1'b0;
      repeat (60) tick();
      check("rst_no_pulses", (n_done - d0) + (n_err - e0), 0);
      check("rst_ready", tx_ready, 1);
      send_frame(8'hF4, 1'b1, "f4");

      // 6: tx_valid held with changing data
      d0 = n_done;
      e0 = n_err;
      start_tx(8'h5A, 1'b1, "hold");
      scramble = 1'b1;
      measure_inhibit("hold");
      run_device(1'b1, fr);
      check("hold_frame1", fr, exp_frame(8'h5A));
      wait_ready("hold");
      captured = tx_data;
      scramble = 1'b0;
      tick();
      check("hold_second_accept", tx_ready, 0);
      check("hold_second_clk_oe", ps2_clk_oe, 1);
      check("hold_done1", n_done - d0, 1);
      tx_valid = 1'b0;
      measure_inhibit("hold2");
      run_device(1'b1, fr);
      check("hold_frame2", fr, exp_frame(captured));
      wait_ready("hold2");
      tick();
      check("hold_done2", n_done - d0, 2);
      check("hold_no_err", n_err - e0, 0);

      check("never_both", n_both, 0);
      if (n_pass + n_fail != n_total)
         $display("FAIL bookkeeping: observed %0d expected %0d", n_pass + n_fail, n_total);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
